// File: rtl/gci_std_kmc_ps2_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// gci_std_kmc_ps2_transmitter_pkg
// Shared definitions for the host-to-device PS/2 transmitter:
//   - transmitter FSM state encoding
//   - default timing / filter parameter values (50 MHz system clock)
//   - frame edge indices used by the edge counter
//   - odd-parity helper
// -----------------------------------------------------------------------------
package gci_std_kmc_ps2_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_FIN       = 3'd6
    } tx_state_t;

    // 120 us clock inhibit, 5 us data setup, 15 ms transaction limit at 50 MHz.
    localparam int DEF_INHIBIT_CYCLES = 6000;
    localparam int DEF_SETUP_CYCLES   = 250;
    localparam int DEF_TIMEOUT_CYCLES = 750000;
    localparam int DEF_FILTER         = 2;

    // Edge counter value held just before the fall that puts the stop bit out.
    localparam logic [3:0] EDGE_BEFORE_STOP = 4'd9;

    // Odd parity: the 9-bit {parity, data} word always carries an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/gci_std_kmc_ps2_tx_linefilter.sv
// -----------------------------------------------------------------------------
// gci_std_kmc_ps2_tx_linefilter
// Brings the raw open-drain PS/2 clock and data pins into the system clock
// domain and debounces them.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   ps2_clk_raw  : raw PS/2 clock pin level
//   ps2_data_raw : raw PS/2 data pin level
//   ps2_clk_f    : filtered clock level
//   ps2_data_f   : filtered data level
//   fall         : one-cycle pulse on each filtered clock 1->0 transition
// A filtered level changes only after P_FILTER equal consecutive synchronized
// samples, so an edge on a pin shows up 2 + P_FILTER cycles later.
// -----------------------------------------------------------------------------
module gci_std_kmc_ps2_tx_linefilter
    import gci_std_kmc_ps2_transmitter_pkg::*;
#(
    parameter int P_FILTER = DEF_FILTER
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_raw,
    input  logic ps2_data_raw,
    output logic ps2_clk_f,
    output logic ps2_data_f,
    output logic fall
);

    logic [1:0]          clk_sync_r;
    logic [1:0]          data_sync_r;
    logic [P_FILTER-1:0] clk_hist_r;
    logic [P_FILTER-1:0] data_hist_r;
    logic                clk_f_r;
    logic                data_f_r;
    logic                fall_r;
    logic                clk_all_hi_s;
    logic                clk_all_lo_s;
    logic                data_all_hi_s;
    logic                data_all_lo_s;

    // Agreement of the whole sample history decides a line change.
    always_comb begin
        clk_all_hi_s  = &clk_hist_r;
        clk_all_lo_s  = ~|clk_hist_r;
        data_all_hi_s = &data_hist_r;
        data_all_lo_s = ~|data_hist_r;
    end

    // Synchronize the pins, shift the sample history and update filtered levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle bus is released (high); starting there avoids a fake fall.
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
            clk_hist_r  <= '1;
            data_hist_r <= '1;
            clk_f_r     <= 1'b1;
            data_f_r    <= 1'b1;
            fall_r      <= 1'b0;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk_raw};
            data_sync_r <= {data_sync_r[0], ps2_data_raw};
            clk_hist_r  <= (clk_hist_r << 1'b1) | P_FILTER'(clk_sync_r[1]);
            data_hist_r <= (data_hist_r << 1'b1) | P_FILTER'(data_sync_r[1]);

            if (clk_all_hi_s) begin
                clk_f_r <= 1'b1;
            end else if (clk_all_lo_s) begin
                clk_f_r <= 1'b0;
            end else begin
                clk_f_r <= clk_f_r;
            end

            if (data_all_hi_s) begin
                data_f_r <= 1'b1;
            end else if (data_all_lo_s) begin
                data_f_r <= 1'b0;
            end else begin
                data_f_r <= data_f_r;
            end

            // Fires in the same cycle the filtered clock drops to 0.
            fall_r <= clk_f_r & clk_all_lo_s;
        end
    end

    assign ps2_clk_f  = clk_f_r;
    assign ps2_data_f = data_f_r;
    assign fall       = fall_r;

endmodule

// File: rtl/gci_std_kmc_ps2_transmitter.sv
// -----------------------------------------------------------------------------
// gci_std_kmc_ps2_transmitter
// Host-to-device PS/2 byte transmitter: inhibits the clock, puts the start bit
// out, releases the clock, shifts data/parity/stop on device clock falls and
// checks the device acknowledge.
//   iCLOCK        : system clock
//   iRESET_SYNC   : synchronous active-high reset
//   iPS2MOD_REQ   : send request (sampled only while not busy)
//   iPS2MOD_DATA  : byte to send, captured with an accepted request
//   oPS2MOD_BUSY  : transaction in progress (stays 1 through the FIN cycle)
//   oPS2MOD_DONE  : one-cycle pulse at transaction end
//   oPS2MOD_ERROR : with DONE: 1 = no acknowledge or timeout
//   iPS2_CLOCK    : raw PS/2 clock pin
//   iPS2_DATA     : raw PS/2 data pin
//   oPS2_CLOCK_OE : 1 pulls the clock line low
//   oPS2_DATA_OE  : 1 pulls the data line low
// -----------------------------------------------------------------------------
module gci_std_kmc_ps2_transmitter
    import gci_std_kmc_ps2_transmitter_pkg::*;
#(
    parameter int P_INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int P_SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int P_TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int P_FILTER         = DEF_FILTER
) (
    input  logic       iCLOCK,
    input  logic       iRESET_SYNC,
    input  logic       iPS2MOD_REQ,
    input  logic [7:0] iPS2MOD_DATA,
    output logic       oPS2MOD_BUSY,
    output logic       oPS2MOD_DONE,
    output logic       oPS2MOD_ERROR,
    input  logic       iPS2_CLOCK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLOCK_OE,
    output logic       oPS2_DATA_OE
);

    localparam int PHASE_MAX = (P_INHIBIT_CYCLES > P_SETUP_CYCLES) ? P_INHIBIT_CYCLES : P_SETUP_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 32'sd1);
    localparam int TW        = $clog2(P_TIMEOUT_CYCLES + 32'sd1);

    localparam logic [PW-1:0] INHIBIT_LAST = PW'(P_INHIBIT_CYCLES - 32'sd1);
    localparam logic [PW-1:0] SETUP_LAST   = PW'(P_SETUP_CYCLES - 32'sd1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(P_TIMEOUT_CYCLES - 32'sd1);

    tx_state_t     state_r;
    tx_state_t     state_s;
    logic [PW-1:0] phase_cnt_r;
    logic [PW-1:0] phase_cnt_s;
    logic [TW-1:0] tmo_cnt_r;
    logic [TW-1:0] tmo_cnt_s;
    logic [3:0]    edge_cnt_r;
    logic [3:0]    edge_cnt_s;
    logic [8:0]    shift_r;
    logic [8:0]    shift_s;
    logic          err_r;
    logic          err_s;
    logic          data_oe_r;
    logic          data_oe_s;
    logic          clock_oe_r;
    logic          busy_r;
    logic          done_r;
    logic          error_r;
    logic          timeout_s;
    logic          ps2_clk_f;
    logic          ps2_data_f;
    logic          fall;

    gci_std_kmc_ps2_tx_linefilter #(
        .P_FILTER (P_FILTER)
    ) u_linefilter (
        .clk          (iCLOCK),
        .reset        (iRESET_SYNC),
        .ps2_clk_raw  (iPS2_CLOCK),
        .ps2_data_raw (iPS2_DATA),
        .ps2_clk_f    (ps2_clk_f),
        .ps2_data_f   (ps2_data_f),
        .fall         (fall)
    );

    // Next-state, counter, shift register and data-line drive logic.
    always_comb begin
        state_s     = state_r;
        phase_cnt_s = phase_cnt_r;
        tmo_cnt_s   = tmo_cnt_r;
        edge_cnt_s  = edge_cnt_r;
        shift_s     = shift_r;
        err_s       = err_r;
        data_oe_s   = data_oe_r;
        // The limit is measured from the first cycle with the clock released.
        timeout_s   = (tmo_cnt_r == TIMEOUT_LAST);

        case (state_r)
            ST_IDLE: begin
                if (iPS2MOD_REQ) begin
                    state_s     = ST_INHIBIT;
                    phase_cnt_s = '0;
                    tmo_cnt_s   = '0;
                    edge_cnt_s  = 4'd0;
                    shift_s     = {odd_parity(iPS2MOD_DATA), iPS2MOD_DATA};
                    err_s       = 1'b0;
                    data_oe_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_INHIBIT: begin
                if (phase_cnt_r == INHIBIT_LAST) begin
                    state_s     = ST_START;
                    phase_cnt_s = '0;
                    data_oe_s   = 1'b1;          // start bit
                end else begin
                    phase_cnt_s = phase_cnt_r + PW'(1'b1);
                end
            end

            ST_START: begin
                if (phase_cnt_r == SETUP_LAST) begin
                    state_s   = ST_SEND;
                    tmo_cnt_s = '0;
                end else begin
                    phase_cnt_s = phase_cnt_r + PW'(1'b1);
                end
            end

            ST_SEND: begin
                if (timeout_s) begin
                    state_s   = ST_FIN;
                    err_s     = 1'b1;
                    data_oe_s = 1'b0;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TW'(1'b1);
                    if (fall) begin
                        edge_cnt_s = edge_cnt_r + 4'd1;
                        if (edge_cnt_r == EDGE_BEFORE_STOP) begin
                            // Stop bit is a 1: just let go of the line.
                            data_oe_s = 1'b0;
                            state_s   = ST_ACK;
                        end else begin
                            // Falls 1..9: data LSB first, then parity.
                            data_oe_s = ~shift_r[0];
                            shift_s   = {1'b0, shift_r[8:1]};
                        end
                    end else begin
                        edge_cnt_s = edge_cnt_r;
                    end
                end
            end

            ST_ACK: begin
                if (timeout_s) begin
                    state_s   = ST_FIN;
                    err_s     = 1'b1;
                    data_oe_s = 1'b0;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TW'(1'b1);
                    if (fall) begin
                        // Device holds data low during this clock for a good ack.
                        err_s   = ps2_data_f;
                        state_s = ST_WAIT_IDLE;
                    end else begin
                        state_s = ST_ACK;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (timeout_s) begin
                    state_s   = ST_FIN;
                    err_s     = 1'b1;
                    data_oe_s = 1'b0;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TW'(1'b1);
                    if (ps2_clk_f & ps2_data_f) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_WAIT_IDLE;
                    end
                end
            end

            ST_FIN: begin
                state_s   = ST_IDLE;
                data_oe_s = 1'b0;
            end

            default: begin
                state_s   = ST_IDLE;
                data_oe_s = 1'b0;
            end
        endcase
    end

    // State/datapath registers; outputs are registered from the next state so
    // they change on the same edge as the state they belong to.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= '0;
            tmo_cnt_r   <= '0;
            edge_cnt_r  <= 4'd0;
            shift_r     <= 9'd0;
            err_r       <= 1'b0;
            data_oe_r   <= 1'b0;
            clock_oe_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_cnt_r <= phase_cnt_s;
            tmo_cnt_r   <= tmo_cnt_s;
            edge_cnt_r  <= edge_cnt_s;
            shift_r     <= shift_s;
            err_r       <= err_s;
            data_oe_r   <= data_oe_s;
            clock_oe_r  <= (state_s == ST_INHIBIT) | (state_s == ST_START);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_FIN);
            error_r     <= (state_s == ST_FIN) & err_s;
        end
    end

    assign oPS2MOD_BUSY  = busy_r;
    assign oPS2MOD_DONE  = done_r;
    assign oPS2MOD_ERROR = error_r;
    assign oPS2_CLOCK_OE = clock_oe_r;
    assign oPS2_DATA_OE  = data_oe_r;

endmodule

// File: tb/tb_gci_std_kmc_ps2_transmitter.sv
// -----------------------------------------------------------------------------
// tb_gci_std_kmc_ps2_transmitter
// Directed bench with a PS/2 device model on open-drain lines. Each request
// pushes its expected frame and result onto a scoreboard queue; the device
// model compares the bits it clocks in, and the DONE handler pops the result.
// -----------------------------------------------------------------------------
module tb_gci_std_kmc_ps2_transmitter;

    localparam int INHIBIT = 20;
    localparam int SETUP   = 5;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;     // half of the 40-cycle device clock period

    typedef struct packed {
        logic [7:0] data;
        logic       parity;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       req;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       error;
    logic       clock_oe;
    logic       data_oe;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2_clock_pin;
    logic       ps2_data_pin;

    int   checks;
    int   failures;
    int   done_cnt;
    exp_t exp_q[$];

    // Wired-AND of host and device pull-downs.
    assign ps2_clock_pin = ~(clock_oe | dev_clk_low);
    assign ps2_data_pin  = ~(data_oe | dev_data_low);

    gci_std_kmc_ps2_transmitter #(
        .P_INHIBIT_CYCLES (INHIBIT),
        .P_SETUP_CYCLES   (SETUP),
        .P_TIMEOUT_CYCLES (TIMEOUT),
        .P_FILTER         (2)
    ) dut (
        .iCLOCK        (clk),
        .iRESET_SYNC   (rst),
        .iPS2MOD_REQ   (req),
        .iPS2MOD_DATA  (wdata),
        .oPS2MOD_BUSY  (busy),
        .oPS2MOD_DONE  (done),
        .oPS2MOD_ERROR (error),
        .iPS2_CLOCK    (ps2_clock_pin),
        .iPS2_DATA     (ps2_data_pin),
        .oPS2_CLOCK_OE (clock_oe),
        .oPS2_DATA_OE  (data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle DONE is high.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic logic exp_parity(input logic [7:0] d);
        return (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [7:0] d, input logic e, input bit hold);
        exp_t x;
        @(negedge clk);
        req   = 1'b1;
        wdata = d;
        x.data   = d;
        x.parity = exp_parity(d);
        x.err    = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        wdata = ~d;      // must not leak into the frame being sent
    endtask

    task automatic device_run(input bit ack, input int abort_at, input string tag);
        logic [9:0] frame;
        int         w;
        bit         stop;
        frame = 10'd0;
        w     = 0;
        stop  = 1'b0;
        while (!(data_oe === 1'b1 && clock_oe === 1'b0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_release"}, 32'(w < 500), 32'd1);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 11 && !stop; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i + 1 == abort_at) begin
                check({tag, "_pre_reset_data_oe"}, 32'(data_oe), 32'd1);
                rst = 1'b1;
                @(negedge clk);
                check({tag, "_reset_lines_busy"}, 32'({clock_oe, data_oe, busy}), 32'd0);
                rst         = 1'b0;
                dev_clk_low = 1'b0;
                stop        = 1'b1;
            end else begin
                dev_clk_low = 1'b0;
                if (i < 10) frame[i] = ps2_data_pin;
                if (i == 9 && ack) dev_data_low = 1'b1;
                if (i == 10) dev_data_low = 1'b0;
                else repeat (HALF) @(negedge clk);
            end
        end
        if (!stop) begin
            check({tag, "_frame"}, 32'(frame), 32'({1'b1, exp_q[0].parity, exp_q[0].data}));
        end
    endtask

    task automatic expect_done(input string tag, input bit drop_req, output int waited);
        exp_t x;
        bit   got;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 3000) begin
            @(negedge clk);
            waited++;
            if (done === 1'b1) got = 1'b1;
        end
        if (drop_req) req = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
        x = exp_q.pop_front();
        if (got) begin
            check({tag, "_error"}, 32'(error), 32'(x.err));
            check({tag, "_lines"}, 32'({clock_oe, data_oe}), 32'd0);
            check({tag, "_busy_in_fin"}, 32'(busy), 32'd1);
        end
    endtask

    initial begin
        int   w;
        int   d0;
        int   hi_cnt;
        int   first_d;
        int   first_rel;
        int   busy_seen;
        logic busy1;
        exp_t junk;

        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        req          = 1'b0;
        wdata        = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy, done, error, clock_oe, data_oe}), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Inhibit/setup timing, then the 0xED frame with ack.
        request(8'hED, 1'b0, 1'b0);
        hi_cnt    = 0;
        first_d   = 0;
        first_rel = 0;
        busy1     = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (clock_oe === 1'b1) hi_cnt++;
            if (data_oe === 1'b1 && first_d == 0) first_d = k;
            if (clock_oe === 1'b0 && first_rel == 0) first_rel = k;
        end
        check("busy_first_cycle", 32'(busy1), 32'd1);
        check("clock_oe_high_cycles", 32'(hi_cnt), 32'd25);
        check("data_oe_first_cycle", 32'(first_d), 32'd21);
        check("clock_release_cycle", 32'(first_rel), 32'd26);
        d0 = done_cnt;
        device_run(1'b1, 0, "ed");
        expect_done("ed", 1'b0, w);
        repeat (5) @(negedge clk);
        check("ed_single_done", 32'(done_cnt - d0), 32'd1);
        check("ed_busy_after", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);

        // Parity 0 and parity 1 cases.
        request(8'hF4, 1'b0, 1'b0);
        device_run(1'b1, 0, "f4");
        expect_done("f4", 1'b0, w);
        repeat (20) @(negedge clk);
        request(8'h00, 1'b0, 1'b0);
        device_run(1'b1, 0, "z00");
        expect_done("z00", 1'b0, w);
        repeat (20) @(negedge clk);

        // Device never acknowledges.
        request(8'hA7, 1'b1, 1'b0);
        device_run(1'b0, 0, "noack");
        expect_done("noack", 1'b0, w);
        repeat (20) @(negedge clk);

        // Device never clocks: timeout measured from clock release.
        request(8'h3C, 1'b1, 1'b0);
        w = 0;
        while (clock_oe === 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("timeout_release_seen", 32'(clock_oe), 32'd0);
        expect_done("timeout", 1'b0, w);
        check("timeout_latency", 32'(w), 32'(TIMEOUT));
        repeat (20) @(negedge clk);

        // Request held through the whole transaction: exactly one transfer.
        d0 = done_cnt;
        request(8'h96, 1'b0, 1'b1);
        device_run(1'b1, 0, "hold");
        expect_done("hold", 1'b1, w);
        busy_seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k > 0 && busy === 1'b1) busy_seen++;
        end
        check("hold_no_second_txn", 32'(busy_seen), 32'd0);
        check("hold_single_done", 32'(done_cnt - d0), 32'd1);

        // Reset after the 5th device clock edge: no DONE, then a clean transfer.
        request(8'h00, 1'b0, 1'b0);
        device_run(1'b1, 5, "rst");
        junk = exp_q.pop_front();
        d0   = done_cnt;
        repeat (100) @(negedge clk);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_idle_lines", 32'({busy, clock_oe, data_oe}), 32'd0);
        request(8'h5A, 1'b0, 1'b0);
        device_run(1'b1, 0, "after_rst");
        expect_done("after_rst", 1'b0, w);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
